fp_add_issue_ctrl: RTL

Upstream issue/collect stage for the pipelined single-precision FP adder/subtractor. It accepts operand pairs over a valid/ready handshake and buffers them in an operand FIFO. It issues at most one pair per cycle to the fixed-latency, non-stallable adder and tracks in-flight operations with a tag shift register. Results land in a result FIFO and leave in order over a valid/ready handshake. A credit counter ensures every issued operation always has a result slot.

---
 rtl/fp_add_issue_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/fp_add_issue_ctrl.sv
// fp_add_issue_ctrl: operand FIFO -> fixed-latency adder issue -> in-order result FIFO with credit flow control.
// Define FP_ISSUE_CLASSIFY_EN to build NaN/Inf classification of the result head on out_flags.
module fp_add_issue_ctrl #(
    parameter int DEPTH         = 4,
    parameter int ADDER_LATENCY = 7,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             add_mode,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = 65 + TAG_W;
    localparam int RW = 32 + TAG_W;
    localparam int LW = ADDER_LATENCY;

    logic [OW-1:0]    op_mem [DEPTH];
    logic [RW-1:0]    res_mem [DEPTH];
    logic [PW-1:0]    op_wp, op_rp, op_wp_nxt, op_rp_nxt, res_wp, res_rp;
    logic [CW-1:0]    credits;
    logic [LW-1:0]    sr_v;
    logic [TAG_W-1:0] sr_t [LW];
    logic [OW-1:0]    op_head;
    logic [RW-1:0]    res_head;
    logic             push, issue, op_empty, res_wr, res_rd, res_full;

    always_comb begin
        push      = in_valid && in_ready;
        op_empty  = op_wp == op_rp;
        issue     = !op_empty && credits != '0;
        op_wp_nxt = op_wp + PW'(push);
        op_rp_nxt = op_rp + PW'(issue);
        op_head   = op_mem[op_rp[AW-1:0]];
        res_wr    = sr_v[LW-1];
        res_full  = res_wp == {~res_rp[AW], res_rp[AW-1:0]};
        out_valid = res_wp != res_rp;
        res_rd    = out_valid && out_ready;
        res_head  = res_mem[res_rp[AW-1:0]];
        {out_result, out_tag} = out_valid ? res_head : '0;
    end

    // in_ready is the registered complement of the next-cycle full flag, so a full FIFO refuses even while popping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_wp    <= '0;
            op_rp    <= '0;
            res_wp   <= '0;
            res_rp   <= '0;
            credits  <= CW'(DEPTH);
            sr_v     <= '0;
            in_ready <= 1'b0;
            add_mode <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
        end else begin
            op_wp    <= op_wp_nxt;
            op_rp    <= op_rp_nxt;
            in_ready <= op_wp_nxt != {~op_rp_nxt[AW], op_rp_nxt[AW-1:0]};
            res_wp   <= res_wp + PW'(res_wr);
            res_rp   <= res_rp + PW'(res_rd);
            credits  <= credits - CW'(issue) + CW'(res_rd);
            sr_v     <= (sr_v << 1) | LW'(issue);
            if (issue)
                {add_mode, add_a, add_b} <= op_head[OW-1:TAG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            op_mem[op_wp[AW-1:0]] <= {in_mode, in_a, in_b, in_tag};
        if (res_wr)
            res_mem[res_wp[AW-1:0]] <= {add_result, sr_t[LW-1]};
        sr_t[0] <= op_head[TAG_W-1:0];
        for (int i = 1; i < LW; i++)
            sr_t[i] <= sr_t[i-1];
    end

`ifdef FP_ISSUE_CLASSIFY_EN
    logic exp_max;
    always_comb begin
        exp_max   = &out_result[30:23];
        out_flags = {exp_max && |out_result[22:0], exp_max && ~|out_result[22:0]};
    end
`else
    assign out_flags = 2'b00;
`endif

    a_no_res_overflow: assert property (@(posedge clk) disable iff (!reset) res_wr |-> !res_full);
    a_credit_range:    assert property (@(posedge clk) disable iff (!reset) credits <= CW'(DEPTH));

endmodule
